// File: rtl/imem_boot_loader.sv
// Streams a framed image (header N, N payload words, optional checksum) into instruction
// memory and holds the CPU core in reset until the image has been loaded and verified.
module imem_boot_loader #(
    parameter  int DATA_W      = 32,
    parameter  int DEPTH       = 1024,
    parameter  int CHECKSUM_EN = 1,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [AW:0]       word_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    // Stream handshake: a word transfers on a rising edge where in_valid and in_ready are
    // both high; in_ready is registered and depends only on state, never on in_valid.
    state_t              state_q, state_d;
    logic [AW:0]         n_q, n_d;
    logic [AW:0]         word_count_q, word_count_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                in_ready_q, in_ready_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                xfer;
    logic [AW:0]         hdr_n;

    assign xfer  = in_valid & in_ready_q;
    assign hdr_n = in_data[AW:0];

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_count_d = word_count_q;
        sum_d        = sum_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d      = HDR;
                    word_count_d = '0;
                    sum_d        = '0;
                end
            end
            HDR: begin
                if (xfer) begin
                    if (hdr_n == '0 || hdr_n > DEPTH_N || in_last) begin
                        state_d = ERR;
                    end else begin
                        n_d     = hdr_n;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    // The write is issued even when this word turns out to end the frame badly.
                    mem_we_d     = 1'b1;
                    mem_addr_d   = word_count_q[AW-1:0];
                    mem_wdata_d  = in_data;
                    word_count_d = word_count_q + 1'b1;
                    sum_d        = sum_q + in_data;
                    if (word_count_d == n_q) begin
                        if (CHECKSUM_EN != 0) state_d = in_last ? ERR : CHECK;
                        else                  state_d = in_last ? RUN : ERR;
                    end else if (in_last) begin
                        state_d = ERR;
                    end
                end
            end
            CHECK: begin
                if (xfer) state_d = (in_last && in_data == sum_q) ? RUN : ERR;
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered from the next state so they change on the same edge.
        in_ready_d  = (state_d == HDR) || (state_d == LOAD) || (state_d == CHECK);
        cpu_reset_d = (state_d != RUN);
        done_d      = (state_d == RUN);
        error_d     = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            word_count_q <= '0;
            sum_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            in_ready_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_count_q <= word_count_d;
            sum_q        <= sum_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            in_ready_q   <= in_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;
    assign dbg_state  = state_q;

endmodule
